// File: rtl/udl_count_pkg.sv
// Shared types and constants for the parametrised up/down/load counter.
// Slice width, mode encoding and the per-edge operation decode.
package udl_count_pkg;

   localparam int NIB = 4;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_UP   = 2'd1,
      OP_DN   = 2'd2,
      OP_LD   = 2'd3
   } op_e;

   // ld dominates; conflicting or absent count requests hold
   function automatic op_e dec_op(
      input logic ld,
      input logic up,
      input logic dw
   );
      op_e op;
      if (ld)
         op = OP_LD;
      else if (up && !dw)
         op = OP_UP;
      else if (dw && !up)
         op = OP_DN;
      else
         op = OP_HOLD;
      return op;
   endfunction

endpackage

// File: rtl/udl_count_n_slice4.sv
// 4-bit up/down/load counter slice with local all-ones/all-zeros flags.
// Loads win over counting; the enable arrives already rippled from below.
module udl_slice4
   import udl_count_pkg::*;
#(
   parameter logic [NIB-1:0] RST_VAL = '0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ld,
   input  logic [NIB-1:0] ld_val,
   input  logic           cnt_en,
   input  logic           dir,
   output logic [NIB-1:0] q,
   output logic           utc,
   output logic           dtc
);

   logic [NIB-1:0] q_q;
   logic [NIB-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (ld)
         q_d = ld_val;
      else if (cnt_en)
         q_d = dir ? q_q + 1'b1 : q_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         q_q <= RST_VAL;
      else
         q_q <= q_d;
   end

   assign q   = q_q;
   assign utc = &q_q;
   assign dtc = ~|q_q;

endmodule

// File: rtl/udl_count_n.sv
// Modulo-(top+1) up/down/load counter built from rippled 4-bit slices.
// Limit handling reuses the slice load path to force 0 or top.
module udl_count_n
   import udl_count_pkg::*;
#(
   parameter int               WIDTH   = 16,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D,
   input  logic             ld,
   input  logic             up,
   input  logic             dw,
   input  logic             sat,
   input  logic [WIDTH-1:0] top,
   output logic [WIDTH-1:0] Q,
   output logic             UTC,
   output logic             DTC,
   output logic             wrap
);

   localparam int NS = WIDTH / NIB;

   op_e              op;
   logic             at_top;
   logic             at_zero;
   logic             base_en;
   logic             dir;
   logic             ovr_ld;
   logic [WIDTH-1:0] ovr_val;
   logic             sl_ld;
   logic [WIDTH-1:0] sl_val;
   logic [NS-1:0]    en;
   logic [NS-1:0]    s_utc;
   logic [NS-1:0]    s_dtc;
   logic [WIDTH-1:0] q_v;
   logic             wrap_q;
   logic             wrap_d;

   assign op      = dec_op(ld, up, dw);
   assign at_top  = q_v >= top;
   assign at_zero = q_v == '0;

   always_comb begin
      base_en = 1'b0;
      dir     = 1'b1;
      ovr_ld  = 1'b0;
      ovr_val = '0;
      wrap_d  = 1'b0;
      unique case (op)
         OP_UP: begin
            dir = 1'b1;
            if (!at_top) begin
               base_en = 1'b1;
            end else if (sat == MODE_WRAP) begin
               ovr_ld  = 1'b1;
               ovr_val = '0;
               wrap_d  = 1'b1;
            end
         end
         OP_DN: begin
            dir = 1'b0;
            if (!at_zero) begin
               base_en = 1'b1;
            end else if (sat == MODE_WRAP) begin
               ovr_ld  = 1'b1;
               ovr_val = top;
               wrap_d  = 1'b1;
            end
         end
         OP_LD:   ;
         OP_HOLD: ;
         default: ;
      endcase
   end

   assign sl_ld  = ld | ovr_ld;
   assign sl_val = ld ? D : ovr_val;

   // slice i counts only when every lower slice is at its rollover point
   always_comb begin
      logic acc;
      acc = base_en;
      en  = '0;
      for (int i = 0; i < NS; i++) begin
         en[i] = acc;
         acc   = acc & (dir ? s_utc[i] : s_dtc[i]);
      end
   end

   for (genvar g = 0; g < NS; g++) begin : g_slice
      udl_slice4 #(
         .RST_VAL (RST_VAL[g*NIB +: NIB])
      ) u_slice (
         .clk    (clk),
         .rst    (rst),
         .ld     (sl_ld),
         .ld_val (sl_val[g*NIB +: NIB]),
         .cnt_en (en[g]),
         .dir    (dir),
         .q      (q_v[g*NIB +: NIB]),
         .utc    (s_utc[g]),
         .dtc    (s_dtc[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst)
         wrap_q <= 1'b0;
      else
         wrap_q <= wrap_d;
   end

   assign Q    = q_v;
   assign UTC  = at_top;
   assign DTC  = at_zero;
   assign wrap = wrap_q;

endmodule

// File: doc/udl_count_n.md
Name: udl_count_n

Overview:
Parametrised up/down/load counter, the successor to the fixed 16-bit cascaded UDL counter. It adds:
- configurable width;
- a synchronous reset;
- a runtime-programmable terminal value (modulo-N counting);
- a selectable wrap or saturate mode;
- a registered roll-over pulse.

It serves as the general timing/event counter in the lab designs: timers, frame counters, scoreboard counters.

Parameters:
WIDTH, 16, counter width in bits; must be a multiple of 4 and at least 4.
RST_VAL, 0, value loaded into Q on reset; WIDTH bits wide.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
D  input  WIDTH  parallel load value
ld  input  1  load enable; highest priority after rst
up  input  1  count-up request
dw  input  1  count-down request
sat  input  1  0 = wrap at limits, 1 = saturate (hold) at limits
top  input  WIDTH  terminal value; the count range is 0..top
Q  output  WIDTH  current count, registered
UTC  output  1  combinational, 1 when Q >= top
DTC  output  1  combinational, 1 when Q == 0
wrap  output  1  registered one-cycle pulse, high the cycle after a wrap occurs

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high, on rst.
- Reset: on a rising edge with rst=1, Q <= RST_VAL and wrap <= 0. After reset, UTC and DTC reflect RST_VAL against top.
- Priority per edge: rst > ld > count > hold.
- Load: ld=1 gives Q <= D and wrap <= 0. up, dw and sat are ignored. D may exceed top; this is legal.
- Count enable:
  - up=1 & dw=0: count up.
  - dw=1 & up=0: count down.
  - up=dw=1 or up=dw=0: hold, with wrap <= 0.
- Count up:
  - If Q < top: Q <= Q+1.
  - If Q >= top and sat=0: Q <= 0, wrap <= 1.
  - If Q >= top and sat=1: Q holds, wrap <= 0.
- Count down:
  - If Q > 0: Q <= Q-1.
  - If Q == 0 and sat=0: Q <= top, wrap <= 1.
  - If Q == 0 and sat=1: Q holds, wrap <= 0.
- wrap: high for exactly one cycle per wrap event and cleared on every non-wrapping edge. Back-to-back wraps, for example top=0 while counting, give wrap high on consecutive cycles.
- top=0: the counter stays at 0. With sat=0, every count edge produces a wrap pulse. UTC and DTC are both 1.
- top changed mid-count: takes effect on the next edge. If Q > top when counting up, the next up edge wraps or saturates per sat. Counting down from Q > top decrements normally.
- All-ones top: behaves as a plain binary WIDTH-bit counter. Wrap 2^WIDTH-1 -> 0 going up and 0 -> 2^WIDTH-1 going down.
- Arithmetic: unsigned, WIDTH bits, with no carry beyond WIDTH. Q never takes a value outside 0..max(top, last loaded D).
- Latency: Q changes on the edge where the request is sampled. UTC and DTC follow Q combinationally. wrap asserts on that same edge, so it is visible in the cycle after the request.

Decomposition:
- Package udl_count_pkg:
  - localparam NIB = 4;
  - mode constants MODE_WRAP = 1'b0 and MODE_SAT = 1'b1.
- Sub-module udl_slice4: a 4-bit up/down/load slice with ld, cnt_en, dir, slice-level UTC (all ones) and DTC (all zeros).
- Top level:
  - instantiates WIDTH/4 slices via generate;
  - ripples enable as AND of lower-slice UTC (up) or DTC (down);
  - adds the top comparator and wrap/saturate override: a synchronous load of 0 or top through the slice ld path;
  - holds the wrap register.

Test Plan:
1. Reset and load: WIDTH=16, top=16'h0009, assert rst for 1 cycle -> Q=0, DTC=1, UTC=0, wrap=0. Then ld=1 with D=16'h0005 -> Q=5 next edge.
2. Modulo-10 up-wrap: top=9, sat=0, Q=0, up=1 for 12 cycles -> Q sequence 1..9,0,1,2; wrap high only in the cycle after 9->0.
3. Down-wrap and saturate: top=9, Q=0, dw=1, sat=0 -> Q=9 and wrap pulse. Set sat=1, count down to 0, then 3 more dw edges -> Q stays 0, wrap stays 0, DTC=1.
4. Multi-slice carry: top=16'hFFFF, ld D=16'h0FFF then up -> Q=16'h1000. ld D=16'h1000 then dw -> Q=16'h0FFF. ld D=16'hFFFF then up -> Q=0 and wrap=1.
5. Simultaneous and priority: Q=5, up=dw=1 -> Q holds at 5. Then ld=1, up=1, D=16'h0003 -> Q=3. Then rst=1, ld=1 -> Q=RST_VAL.
6. Load beyond top: top=9, ld D=16'h0020 -> UTC=1. Then up with sat=0 -> Q=0 and wrap=1. Then ld 16'h0020 and dw -> Q=16'h001F.
